// File: rtl/sram_like_bridge_if.sv
// Variable-latency sram-like bus between a CPU port bridge (master) and memory/interconnect (slave).
interface sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_bridge.sv
// Adapts one fixed-latency CPU memory port to the sram-like req/addr_ok/data_ok bus,
// generating the pipeline stall, holding read data across external stalls and dropping flushed accesses.
module sram_like_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int KSEG_MAP = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [1:0]          cpu_size,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    input  logic                ext_stall,
    input  logic                cpu_flush,
    sram_like_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] phys_addr;

    // kseg0 and kseg1 both alias the low 512 MB of physical memory.
    always_comb begin
        phys_addr = cpu_addr;
        if (KSEG_MAP != 0 && cpu_addr[ADDR_W-1 -: 2] == 2'b10)
            phys_addr[ADDR_W-1 -: 3] = 3'b000;
    end

    always_comb begin
        state_d   = state_q;
        cancel_d  = cancel_q;
        rdata_d   = rdata_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bus.req   = 1'b0;
        bus.wr    = wr_q;
        bus.size  = size_q;
        bus.addr  = addr_q;
        bus.wdata = wdata_q;
        cpu_stall = 1'b0;
        cpu_rdata = rdata_q;

        unique case (state_q)
            IDLE: begin
                bus.req   = cpu_en;
                bus.wr    = |cpu_wen;
                bus.size  = cpu_size;
                bus.addr  = phys_addr;
                bus.wdata = cpu_wdata;
                if (cpu_en) begin
                    wr_d      = |cpu_wen;
                    size_d    = cpu_size;
                    addr_d    = phys_addr;
                    wdata_d   = cpu_wdata;
                    cpu_stall = !cpu_flush;
                    cancel_d  = cpu_flush;
                    state_d   = bus.addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                // While cancelled, any cpu_en belongs to a new access that must wait.
                bus.req   = 1'b1;
                cpu_stall = cancel_q ? (cpu_en && !cpu_flush) : !cpu_flush;
                if (cpu_flush)
                    cancel_d = 1'b1;
                if (bus.addr_ok)
                    state_d = DATA;
            end
            DATA: begin
                if (bus.data_ok) begin
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                    if (cancel_q || cpu_flush) begin
                        cpu_stall = cancel_q && cpu_en && !cpu_flush;
                    end else begin
                        rdata_d   = bus.rdata;
                        cpu_rdata = bus.rdata;
                        if (ext_stall)
                            state_d = DONE;
                    end
                end else begin
                    cpu_stall = cancel_q ? (cpu_en && !cpu_flush) : !cpu_flush;
                    if (cpu_flush)
                        cancel_d = 1'b1;
                end
            end
            DONE: begin
                if (!ext_stall || cpu_flush)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!resetn) begin
            bus.req   = 1'b0;
            bus.wr    = 1'b0;
            bus.size  = 2'b00;
            bus.addr  = '0;
            bus.wdata = '0;
            cpu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            rdata_q  <= '0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            rdata_q  <= rdata_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_sram_like_bridge.sv
// Scoreboard bench for sram_like_bridge: directed accesses push expectations, monitors pop and compare.
module tb_sram_like_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ext_stall;
    logic        cpu_flush;
    int          cyc = 0;
    int          check_cnt = 0;
    int          pass_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    sram_like_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .KSEG_MAP(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_size  (cpu_size),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_stall (ext_stall),
        .cpu_flush (cpu_flush),
        .bus       (bus_if.master)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          req_cycles;
    } bus_exp_t;

    typedef struct {
        logic        chk;
        logic [31:0] rdata;
        int          stall_cycles;
    } cpu_exp_t;

    typedef struct {
        int          addr_dly;
        int          data_dly;
        logic [31:0] rdata;
    } resp_cfg_t;

    bus_exp_t  bus_q[$];
    cpu_exp_t  cpu_q[$];
    resp_cfg_t resp_q[$];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory model: addr_ok after addr_dly req cycles, data_ok data_dly cycles after addr_ok.
    initial begin : responder
        int        phase;
        int        cnt;
        resp_cfg_t cur;
        phase = 0;
        cnt   = 0;
        cur   = '{0, 1, 32'h0};
        bus_if.addr_ok = 1'b0;
        bus_if.data_ok = 1'b0;
        bus_if.rdata   = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #2;
            bus_if.addr_ok = 1'b0;
            bus_if.data_ok = 1'b0;
            bus_if.rdata   = 32'hDEAD_BEEF;
            if (!resetn) begin
                phase = 0;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    bus_if.data_ok = 1'b1;
                    bus_if.rdata   = cur.rdata;
                    phase = 0;
                end else begin
                    cnt--;
                end
            end else if (bus_if.req) begin
                if (phase == 0) begin
                    if (resp_q.size() > 0) cur = resp_q.pop_front();
                    else                   cur = '{0, 1, 32'h0};
                    cnt   = cur.addr_dly;
                    phase = 1;
                end
                if (cnt == 0) begin
                    bus_if.addr_ok = 1'b1;
                    phase = 2;
                    cnt   = cur.data_dly - 1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin : bus_monitor
        int       req_cnt;
        bus_exp_t e;
        req_cnt = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                req_cnt = 0;
            end else if (bus_if.req) begin
                if (bus_q.size() == 0) begin
                    check_output("unexpected_req", bus_if.req, 0);
                end else begin
                    e = bus_q[0];
                    req_cnt++;
                    check_output("bus_addr", bus_if.addr, e.addr);
                    check_output("bus_wr_size", {bus_if.wr, bus_if.size}, {e.wr, e.size});
                    if (e.wr)
                        check_output("bus_wdata", bus_if.wdata, e.wdata);
                    if (bus_if.addr_ok) begin
                        check_output("req_cycles", req_cnt, e.req_cycles);
                        void'(bus_q.pop_front());
                        req_cnt = 0;
                    end
                end
            end
        end
    end

    // A result is consumed by the pipeline once stall and ext_stall are both low.
    initial begin : cpu_monitor
        int       stall_cnt;
        logic     peeked;
        cpu_exp_t e;
        stall_cnt = 0;
        peeked    = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn || cpu_flush) begin
                stall_cnt = 0;
                peeked    = 1'b0;
            end else if (cpu_en && cpu_stall) begin
                stall_cnt++;
            end else if (cpu_en) begin
                if (cpu_q.size() == 0) begin
                    check_output("unexpected_done", cpu_stall, 1);
                end else begin
                    e = cpu_q[0];
                    if (e.chk)
                        check_output("cpu_rdata", cpu_rdata, e.rdata);
                    if (!peeked)
                        check_output("stall_cycles", stall_cnt, e.stall_cycles);
                    peeked = 1'b1;
                    if (!ext_stall) begin
                        void'(cpu_q.pop_front());
                        stall_cnt = 0;
                        peeked    = 1'b0;
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(
        input logic [31:0] vaddr, input logic [3:0] wen, input logic [1:0] sz,
        input logic [31:0] wd, input int adly, input int ddly, input logic [31:0] mem_rdata,
        input logic [31:0] exp_addr, input int exp_stall, input logic keep,
        input logic chk_hold, input logic [31:0] hold_val);
        bus_exp_t  be;
        cpu_exp_t  ce;
        resp_cfg_t rc;
        logic      done;
        be = '{|wen, sz, exp_addr, wd, adly + 1};
        ce = '{(wen == 4'b0), mem_rdata, exp_stall};
        rc = '{adly, ddly, mem_rdata};
        bus_q.push_back(be);
        cpu_q.push_back(ce);
        resp_q.push_back(rc);
        cpu_en    = 1'b1;
        cpu_wen   = wen;
        cpu_size  = sz;
        cpu_addr  = vaddr;
        cpu_wdata = wd;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
            else if (chk_hold) check_output("held_rdata", cpu_rdata, hold_val);
        end
        if (!done)
            check_output("completion_timeout", cpu_stall, 1'b0);
        @(posedge clk);
        #1;
        if (!keep) cpu_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int start;
        resetn    = 1'b0;
        cpu_en    = 1'b1;
        cpu_wen   = 4'b0;
        cpu_size  = 2'd2;
        cpu_addr  = 32'hBFC0_0000;
        cpu_wdata = 32'h0;
        ext_stall = 1'b0;
        cpu_flush = 1'b0;
        idle_cycles(2);
        @(negedge clk);
        check_output("reset_req", bus_if.req, 0);
        check_output("reset_stall", cpu_stall, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cpu_en = 1'b0;
        @(negedge clk);
        check_output("reset_rdata", cpu_rdata, 0);
        check_output("idle_req", bus_if.req, 0);
        idle_cycles(1);

        // Read through kseg1, data_ok one idle cycle after addr_ok.
        apply_stimulus(32'hBFC0_0000, 4'b0000, 2'd2, 32'h0, 0, 2, 32'h1234_5678,
                       32'h1FC0_0000, 2, 1'b0, 1'b0, 32'h0);
        idle_cycles(1);

        // Halfword write with addr_ok held off for three cycles.
        apply_stimulus(32'h8000_0010, 4'b1100, 2'd1, 32'hA5A5_0000, 3, 1, 32'h0,
                       32'h0000_0010, 4, 1'b0, 1'b0, 32'h0);
        idle_cycles(1);

        // Read completing under ext_stall: held in DONE while bus rdata changes.
        ext_stall = 1'b1;
        apply_stimulus(32'h8000_0040, 4'b0000, 2'd2, 32'h0, 1, 1, 32'hCAFE_F00D,
                       32'h0000_0040, 2, 1'b1, 1'b0, 32'h0);
        idle_cycles(4);
        ext_stall = 1'b0;
        idle_cycles(1);
        cpu_en = 1'b0;
        idle_cycles(1);

        // Flush during DATA, then a new read that must wait for the old data_ok.
        bus_q.push_back('{1'b0, 2'd2, 32'h0000_0200, 32'h0, 1});
        resp_q.push_back('{0, 4, 32'hBAD0_BAD0});
        cpu_en   = 1'b1;
        cpu_wen  = 4'b0;
        cpu_size = 2'd2;
        cpu_addr = 32'h0000_0200;
        idle_cycles(1);
        cpu_flush = 1'b1;
        @(negedge clk);
        check_output("flush_stall", cpu_stall, 0);
        idle_cycles(1);
        cpu_flush = 1'b0;
        apply_stimulus(32'h0000_0100, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h1357_9BDF,
                       32'h0000_0100, 4, 1'b0, 1'b1, 32'hCAFE_F00D);
        idle_cycles(1);

        // Back-to-back reads, one every two cycles.
        start = cyc;
        apply_stimulus(32'h0000_1000, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h1111_0001,
                       32'h0000_1000, 1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(32'hA000_2000, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h2222_0002,
                       32'h0000_2000, 1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(32'hC000_3000, 4'b0000, 2'd0, 32'h0, 0, 1, 32'h3333_0003,
                       32'hC000_3000, 1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(32'h9FC0_0004, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h4444_0004,
                       32'h1FC0_0004, 1, 1'b0, 1'b0, 32'h0);
        check_output("b2b_cycles", cyc - start, 8);
        idle_cycles(1);

        // Reset while waiting for addr_ok.
        bus_q.push_back('{1'b0, 2'd2, 32'h0000_0300, 32'h0, 11});
        resp_q.push_back('{10, 1, 32'h0});
        cpu_en   = 1'b1;
        cpu_wen  = 4'b0;
        cpu_size = 2'd2;
        cpu_addr = 32'h8000_0300;
        idle_cycles(1);
        @(negedge clk);
        check_output("addr_phase_req", bus_if.req, 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        cpu_en = 1'b0;
        idle_cycles(1);
        resetn = 1'b1;
        bus_q.delete();
        @(negedge clk);
        check_output("post_reset_req", bus_if.req, 0);
        check_output("post_reset_stall", cpu_stall, 0);
        check_output("post_reset_rdata", cpu_rdata, 0);
        idle_cycles(1);

        apply_stimulus(32'h0000_0400, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h0F0F_0F0F,
                       32'h0000_0400, 1, 1'b0, 1'b0, 32'h0);
        idle_cycles(3);

        check_output("bus_q_drained", bus_q.size(), 0);
        check_output("cpu_q_drained", cpu_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
